// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl
//
// Sequencer for the multiply/divide resource. A request accepted in IDLE
// runs 32 iterations of a signed radix-2 Booth multiply or a restoring
// divide on magnitudes. The result is then presented for one FINISH cycle
// together with single-cycle HI/LO write strobes.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   start      in   operation request (sampled only in IDLE)
//   op_mult    in   1 = MULT, 0 = DIV
//   a, b       in   32-bit signed operands (sampled with start)
//   busy       out  operation in progress (first iteration through FINISH)
//   done       out  one-cycle completion pulse (FINISH)
//   hi_write   out  HI register load strobe
//   lo_write   out  LO register load strobe
//   div_mult   out  latched op_mult of the current/last operation
//   hi_out     out  MULT product[63:32] / DIV remainder
//   lo_out     out  MULT product[31:0]  / DIV quotient
//   div_zero   out  divide-by-zero pulse, coincident with done
//
// Build option
//   MULTDIV_DIVZERO_TRAP_EN : when defined, DIV with b == 0 skips the
//   iterations and completes in one cycle with div_zero set and no HI/LO
//   strobes. When undefined, div_zero is tied low and a divide by zero runs
//   the normal 32 iterations.
// ---------------------------------------------------------------------------
module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op_mult,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        hi_write,
    output logic        lo_write,
    output logic        div_mult,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic        dz_q, dz_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [64:0] acc_q, acc_d;     // Booth accumulator {P_hi, P_lo, q-1}
    logic [32:0] rem_q, rem_d;     // partial remainder
    logic [31:0] dq_q, dq_d;       // dividend bits out at the top, quotient bits in at the bottom
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // ---------------- Booth step ----------------
    // The add/subtract is done at 33 bits so that P_hi +/- a never overflows
    // (matters for a = 0x80000000); the arithmetic shift then drops the
    // extra bit back into the 65-bit accumulator.
    logic [32:0] p_hi_ext;
    logic [32:0] a_ext;
    logic [32:0] booth_sum;
    logic [64:0] acc_step;

    always_comb begin
        p_hi_ext = {acc_q[64], acc_q[64:33]};
        a_ext    = {a_q[31], a_q};
        case (acc_q[1:0])
            2'b01:   booth_sum = p_hi_ext + a_ext;
            2'b10:   booth_sum = p_hi_ext - a_ext;
            default: booth_sum = p_hi_ext;
        endcase
        acc_step = {booth_sum, acc_q[32:1]};
    end

    // ---------------- Restoring divide step ----------------
    logic [31:0] b_mag;
    logic [33:0] rem_shift;
    logic        rem_ge;
    logic [32:0] rem_trial;

    always_comb begin
        b_mag     = b_q[31] ? (32'd0 - b_q) : b_q;
        rem_shift = {rem_q, dq_q[31]};
        rem_ge    = (rem_shift >= {2'b00, b_mag});
        rem_trial = rem_shift[32:0] - {1'b0, b_mag};
    end

    // ---------------- Final result with sign correction ----------------
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        if (op_q) begin
            res_hi = acc_q[64:33];
            res_lo = acc_q[32:1];
        end else begin
            res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - dq_q) : dq_q;
            res_hi = a_q[31] ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
        end
    end

    // ---------------- Next state / outputs ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dz_d     = dz_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        dq_d     = dq_q;

        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        hi_out   = hi_q;
        lo_out   = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_mult;
                    dz_d    = 1'b0;
                    cnt_d   = 5'd31;
                    acc_d   = {32'd0, b, 1'b0};
                    rem_d   = 33'd0;
                    dq_d    = a[31] ? (32'd0 - a) : a;
                    state_d = op_mult ? S_MULT : S_DIV;
`ifdef MULTDIV_DIVZERO_TRAP_EN
                    if (!op_mult && (b == 32'd0)) begin
                        dz_d    = 1'b1;
                        state_d = S_FINISH;
                    end
`endif
                end
            end
            S_MULT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_FINISH;
                end
            end
            S_DIV: begin
                rem_d = rem_ge ? rem_trial : rem_shift[32:0];
                dq_d  = {dq_q[30:0], rem_ge};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
                // A trapped divide leaves the presented result untouched.
                if (!dz_q) begin
                    hi_write = 1'b1;
                    lo_write = 1'b1;
                    hi_out   = res_hi;
                    lo_out   = res_lo;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The presented value is what stays visible until the next FINISH.
        hi_d = hi_out;
        lo_d = lo_out;
    end

    assign div_mult = op_q;

`ifdef MULTDIV_DIVZERO_TRAP_EN
    assign div_zero = (state_q == S_FINISH) && dz_q;
`else
    assign div_zero = 1'b0;
`endif

    // ---------------- State registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            acc_q   <= 65'd0;
            rem_q   <= 33'd0;
            dq_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_ctrl
//
// Self-checking bench for multdiv_ctrl. A behavioural model derives the
// expected results with plain 64-bit arithmetic and tracks when each
// operation finishes. A per-cycle compare process checks every output
// against that model. Directed operations additionally pin the results to
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op_mult = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, hi_write, lo_write, div_mult, div_zero;
    logic [31:0] hi_out, lo_out;

    int n_chk  = 0;
    int n_fail = 0;

    multdiv_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op_mult  (op_mult),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .div_mult (div_mult),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- Behavioural model ----------------
`ifdef MULTDIV_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    function automatic bit model_trap(input logic op, input logic [31:0] y);
        return TRAP && !op && (y == 32'd0);
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] model_res(input logic op, input logic [31:0] x, input logic [31:0] y);
        longint      p;
        logic [31:0] ux, uy, q, r, lo, hi;
        if (op) begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
        end
        ux = x[31] ? (32'd0 - x) : x;
        uy = y[31] ? (32'd0 - y) : y;
        if (uy == 32'd0) begin
            lo = x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            hi = x;
        end else begin
            q  = ux / uy;
            r  = ux % uy;
            lo = (x[31] != y[31]) ? (32'd0 - q) : q;
            hi = x[31] ? (32'd0 - r) : r;
        end
        return {hi, lo};
    endfunction

    int          ecnt = 0;        // number of rising edges so far; cycle label
    bit          m_act = 1'b0;    // an operation has been accepted since reset
    int          m_fin = 0;       // label of that operation's FINISH cycle
    bit          m_op = 1'b0;
    bit          m_trap = 1'b0;
    logic [31:0] m_new_hi = 32'd0, m_new_lo = 32'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    always @(posedge clock) ecnt <= ecnt + 1;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_act  <= 1'b0;
            m_fin  <= 0;
            m_op   <= 1'b0;
            m_trap <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            if (m_act && (ecnt + 1 == m_fin) && !m_trap) begin
                m_hi <= m_new_hi;
                m_lo <= m_new_lo;
            end
            // Accepted only when the cycle ending at this edge was idle.
            if (start && !(m_act && ecnt <= m_fin)) begin
                m_act    <= 1'b1;
                m_op     <= op_mult;
                m_trap   <= model_trap(op_mult, b);
                m_fin    <= ecnt + 1 + (model_trap(op_mult, b) ? 0 : 32);
                {m_new_hi, m_new_lo} <= model_res(op_mult, a, b);
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge clock) begin
        logic e_busy, e_done;
        e_busy = m_act && (ecnt <= m_fin);
        e_done = m_act && (ecnt == m_fin);
        chk("busy",     busy,     e_busy);
        chk("done",     done,     e_done);
        chk("hi_write", hi_write, e_done && !m_trap);
        chk("lo_write", lo_write, e_done && !m_trap);
        chk("div_zero", div_zero, e_done && m_trap);
        chk("div_mult", div_mult, m_op);
        chk("hi_out",   hi_out,   m_hi);
        chk("lo_out",   lo_out,   m_lo);
    end

    // ---------------- Directed operation ----------------
    task automatic run_op(input string nm, input logic op, input logic [31:0] av, input logic [31:0] bv,
                          input int lat, input logic [31:0] eh, input logic [31:0] el,
                          input logic wr, input logic dz);
        int n;
        bit seen;
        @(posedge clock); #1;
        start = 1'b1; op_mult = op; a = av; b = bv;
        @(posedge clock); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clock);
            if (done) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: no done within 40 cycles, expected after %0d", nm, lat);
        end else begin
            chk({nm, "_latency"}, n, lat);
            chk({nm, "_hi"}, hi_out, eh);
            chk({nm, "_lo"}, lo_out, el);
            chk({nm, "_hi_write"}, hi_write, wr);
            chk({nm, "_lo_write"}, lo_write, wr);
            chk({nm, "_div_zero"}, div_zero, dz);
            chk({nm, "_div_mult"}, div_mult, op);
            $display("op %s: op_mult=%0d a=%08h b=%08h latency=%0d hi=%08h lo=%08h", nm, op, av, bv, n, hi_out, lo_out);
        end
        @(negedge clock);
        chk({nm, "_done_1cyc"}, done, 1'b0);
        chk({nm, "_hiw_1cyc"}, hi_write, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [5];
        sp[0] = 32'h0000_0000; sp[1] = 32'h0000_0001; sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h8000_0000; sp[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return $urandom_range(0, 20) - 10;
        return $urandom;
    endfunction

    initial begin
        int cnt;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        run_op("mul_7_m3",   1'b1, 32'd7,          32'hFFFF_FFFD, 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1, 1'b0);
        run_op("mul_min_min",1'b1, 32'h8000_0000,  32'h8000_0000, 32, 32'h4000_0000, 32'h0000_0000, 1'b1, 1'b0);
        run_op("div_m7_2",   1'b0, 32'hFFFF_FFF9,  32'd2,         32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
        run_op("div_min_m1", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
        if (TRAP)
            run_op("div_5_0", 1'b0, 32'd5, 32'd0, 0, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        else
            run_op("div_5_0", 1'b0, 32'd5, 32'd0, 32, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // start held high: one operation every 34 cycles
        @(posedge clock); #1;
        start = 1'b1; op_mult = 1'b1; a = 32'd3; b = 32'd5;
        cnt = 0;
        repeat (102) begin
            @(negedge clock);
            if (done) cnt++;
        end
        @(posedge clock); #1;
        start = 1'b0;
        chk("cont_start_dones", cnt, 3);
        repeat (3) @(posedge clock);

        // Asynchronous reset in the middle of an operation
        #1;
        start = 1'b1; op_mult = 1'b1; a = 32'd9; b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_hiw", hi_write, 1'b0);
        chk("arst_divmult", div_mult, 1'b0);
        chk("arst_hi", hi_out, 32'd0);
        chk("arst_lo", lo_out, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) cnt++;
        end
        chk("arst_no_done", cnt, 0);
        run_op("mul_3_4", 1'b1, 32'd3, 32'd4, 32, 32'd0, 32'd12, 1'b1, 1'b0);

        // Randomised traffic, including start while busy
        repeat (2500) begin
            @(posedge clock); #1;
            start   = ($urandom_range(0, 3) == 0);
            op_mult = 1'($urandom_range(0, 1));
            a       = pick();
            b       = pick();
        end
        @(posedge clock); #1;
        start = 1'b0;
        repeat (40) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
